// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between the producers, the round-robin arbiter and the
// FIFO write port. The arbiter takes the master view: it consumes the
// producer requests and data and the FIFO full flag, and it drives the
// grants and the FIFO's enqueue/data_in.
interface fifo_write_arbiter_if #(
    parameter int requesters = 4,
    parameter int bit_width  = 8
);
    localparam int owner_width = $clog2(requesters);

    logic [requesters-1:0]           request;
    logic [requesters*bit_width-1:0] req_data;
    logic                            full;
    logic [requesters-1:0]           grant;
    logic                            enqueue;
    logic [bit_width-1:0]            data_in;
    logic [owner_width-1:0]          owner;
    logic                            busy;

    modport master (
        input  request,
        input  req_data,
        input  full,
        output grant,
        output enqueue,
        output data_in,
        output owner,
        output busy
    );

    modport slave (
        output request,
        output req_data,
        output full,
        input  grant,
        input  enqueue,
        input  data_in,
        input  owner,
        input  busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between several producers.
// A producer holds the port for a burst of at most max_burst beats. A beat is
// a cycle in which the owner requests and the FIFO is not full. The burst ends
// when the owner drops its request or uses its last beat, and every burst is
// followed by one idle arbitration cycle.
module fifo_write_arbiter #(
    parameter int requesters = 4,
    parameter int bit_width  = 8,
    parameter int max_burst  = 4
) (
    input  logic                  write_clock,
    input  logic                  reset,
    fifo_write_arbiter_if.master  bus
);
    localparam int owner_width = $clog2(requesters);
    localparam int beats_width = $clog2(max_burst + 1);

    // Index 0 gets first priority after reset because the scan starts at last+1.
    localparam logic [owner_width-1:0] last_init   = owner_width'(requesters - 1);
    // beats+1 == max_burst is the same as beats == max_burst-1.
    localparam logic [beats_width-1:0] final_beat  = beats_width'(max_burst - 1);
    localparam logic [owner_width:0]   wrap_limit  = (owner_width + 1)'(requesters);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state_reg,  state_next;
    logic [owner_width-1:0]  owner_reg,  owner_next;
    logic [owner_width-1:0]  last_reg,   last_next;
    logic [beats_width-1:0]  beats_reg,  beats_next;
    logic [requesters-1:0]   grant_reg,  grant_next;

    logic [bit_width-1:0]    data_slice [requesters];
    logic [owner_width-1:0]  scan_idx   [requesters];
    logic [requesters-1:0]   scan_hit;
    logic [requesters-1:0]   winner_onehot;
    logic [owner_width-1:0]  winner;
    logic                    any_request;
    logic                    owner_request;
    logic                    beat;

    // Per-producer data lanes, so the owner can pick its word by index.
    for (genvar gi = 0; gi < requesters; gi++) begin : g_slice
        assign data_slice[gi] = bus.req_data[gi*bit_width +: bit_width];
    end

    // Scan order: offset gi looks at index (last+1+gi) mod requesters.
    // last <= requesters-1, so one conditional subtraction covers the wrap.
    for (genvar gi = 0; gi < requesters; gi++) begin : g_scan
        logic [owner_width:0] scan_sum;
        assign scan_sum     = {1'b0, last_reg} + (owner_width + 1)'(gi + 1);
        assign scan_idx[gi] = (scan_sum >= wrap_limit)
                            ? owner_width'(scan_sum - wrap_limit)
                            : scan_sum[owner_width-1:0];
        assign scan_hit[gi] = bus.request[scan_idx[gi]];
    end

    // Pick the requester at the smallest scan offset; walking offsets from
    // high to low lets the nearest hit overwrite the farther ones.
    always_comb begin
        winner = scan_idx[0];
        for (int i = requesters - 1; i >= 0; i--) begin
            if (scan_hit[i]) begin
                winner = scan_idx[i];
            end
        end
    end

    // One-hot form of the winner, loaded into the grant register on a new burst.
    for (genvar gi = 0; gi < requesters; gi++) begin : g_onehot
        assign winner_onehot[gi] = (winner == owner_width'(gi));
    end

    assign any_request   = |bus.request;
    assign owner_request = bus.request[owner_reg];
    // A beat is the only way a word reaches the FIFO; never while it is full.
    assign beat          = (state_reg == BURST) && owner_request && !bus.full;

    assign bus.enqueue = beat;
    assign bus.data_in = data_slice[owner_reg];
    assign bus.grant   = grant_reg;
    assign bus.owner   = owner_reg;
    assign bus.busy    = (state_reg == BURST);

    // Next-state logic: arbitrate in IDLE, count beats and detect burst end in BURST.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        beats_next = beats_reg;
        grant_next = grant_reg;
        case (state_reg)
            IDLE: begin
                if (any_request && !bus.full) begin
                    state_next = BURST;
                    owner_next = winner;
                    beats_next = '0;
                    grant_next = winner_onehot;
                end
            end
            BURST: begin
                if (!owner_request || (beat && (beats_reg == final_beat))) begin
                    // Burst over: remember who had it so the next scan starts after it.
                    state_next = IDLE;
                    last_next  = owner_reg;
                    owner_next = '0;
                    beats_next = '0;
                    grant_next = '0;
                end else if (beat) begin
                    beats_next = beats_reg + beats_width'(1);
                end
                // full=1 with the owner still requesting: stall, nothing changes.
            end
            default: begin
                state_next = IDLE;
                owner_next = '0;
                beats_next = '0;
                grant_next = '0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge write_clock) begin
        if (reset) begin
            state_reg <= IDLE;
            owner_reg <= '0;
            last_reg  <= last_init;
            beats_reg <= '0;
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            beats_reg <= beats_next;
            grant_reg <= grant_next;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: a burst-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fifo_write_arbiter;
    localparam int R  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic         write_clock = 1'b0;
    logic         reset;
    logic [R-1:0] req_drv;
    logic         full_drv;
    bit           fifo_mode;
    int           fifo_count;
    int           word_cnt [R];

    int total = 0;
    int bad   = 0;

    always #5 write_clock = ~write_clock;

    fifo_write_arbiter_if #(.requesters(R), .bit_width(W)) bus ();

    fifo_write_arbiter #(.requesters(R), .bit_width(W), .max_burst(MB)) dut (
        .write_clock (write_clock),
        .reset       (reset),
        .bus         (bus)
    );

    // Producer k presents word k*64 + (number of its accepted words).
    assign bus.request = req_drv;
    assign bus.full    = fifo_mode ? (fifo_count >= 3) : full_drv;
    for (genvar gi = 0; gi < R; gi++) begin : g_prod
        assign bus.req_data[gi*W +: W] = W'(gi * 64 + (word_cnt[gi] % 64));
    end

    // Producers advance on accepted words; the capacity-3 FIFO fills and is never read.
    always @(posedge write_clock) begin
        for (int k = 0; k < R; k++) begin
            if (reset)
                word_cnt[k] <= 0;
            else if (bus.grant[k] && bus.request[k] && !bus.full)
                word_cnt[k] <= word_cnt[k] + 1;
        end
        if (reset)
            fifo_count <= 0;
        else if (bus.enqueue && !bus.full)
            fifo_count <= fifo_count + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: burst owner (or none), beats used, last owner.
    bit m_valid = 1'b0;
    bit m_busy;
    int m_owner;
    int m_beats;
    int m_last;
    int enq_seen       = 0;
    int enq_while_full = 0;
    int grant_02_seen  = 0;

    // Compare DUT against the model mid-cycle, then advance the model.
    always @(negedge write_clock) begin
        logic [R-1:0] exp_grant;
        logic         exp_enq;
        logic [W-1:0] exp_data;
        if (m_valid) begin
            exp_grant = '0;
            if (m_busy) exp_grant[m_owner] = 1'b1;
            exp_enq  = m_busy && bus.request[m_owner] && !bus.full;
            exp_data = bus.req_data[m_owner*W +: W];
            check("cyc_grant",   bus.grant,   exp_grant);
            check("cyc_enqueue", bus.enqueue, exp_enq);
            check("cyc_data_in", bus.data_in, exp_data);
            check("cyc_owner",   bus.owner,   m_owner);
            check("cyc_busy",    bus.busy,    m_busy);
        end
        if (bus.enqueue === 1'b1) begin
            enq_seen++;
            $display("beat: owner=%0d data=%02h t=%0t", bus.owner, bus.data_in, $time);
        end
        if (bus.enqueue === 1'b1 && bus.full === 1'b1) enq_while_full++;
        if (bus.grant[0] === 1'b1 || bus.grant[2] === 1'b1) grant_02_seen++;

        if (reset) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_owner = 0;
            m_beats = 0;
            m_last  = R - 1;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (bus.request != '0 && !bus.full) begin
                    for (int d = 1; d <= R; d++) begin
                        if (bus.request[(m_last + d) % R]) begin
                            m_owner = (m_last + d) % R;
                            break;
                        end
                    end
                    m_busy  = 1'b1;
                    m_beats = 0;
                end
            end else if (!bus.request[m_owner]) begin
                m_last  = m_owner;
                m_busy  = 1'b0;
                m_owner = 0;
            end else if (!bus.full) begin
                m_beats++;
                if (m_beats == MB) begin
                    m_last  = m_owner;
                    m_busy  = 1'b0;
                    m_owner = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge write_clock);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0: reset just released, IDLE.
    task automatic do_reset();
        reset     = 1'b1;
        req_drv   = '0;
        full_drv  = 1'b0;
        fifo_mode = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, g0, w0;
        reset    = 1'b1;
        req_drv  = '0;
        full_drv = 1'b0;

        // Single burst from producer 0.
        do_reset();
        req_drv = 4'b0001;
        #1;
        check("t1_reset_grant", bus.grant, 4'b0000);
        check("t1_reset_busy",  bus.busy, 1'b0);
        check("t1_reset_owner", bus.owner, 2'd0);
        check("t1_reset_enq",   bus.enqueue, 1'b0);
        e0 = enq_seen;
        tick(1); #1;
        check("t1_c1_grant", bus.grant, 4'b0001);
        check("t1_c1_data",  bus.data_in, 8'h00);
        check("t1_c1_enq",   bus.enqueue, 1'b1);
        tick(3); #1;
        check("t1_c4_data",  bus.data_in, 8'h03);
        tick(1); #1;
        check("t1_c5_grant", bus.grant, 4'b0000);
        check("t1_beats",    enq_seen - e0, 4);
        tick(1); #1;
        check("t1_c6_grant", bus.grant, 4'b0001);
        check("t1_c6_data",  bus.data_in, 8'h04);

        // Round-robin between producers 1 and 3.
        do_reset();
        req_drv = 4'b1010;
        #1;
        g0 = grant_02_seen;
        tick(1); #1;
        check("t2_c1_grant",  bus.grant, 4'b0010);
        tick(5); #1;
        check("t2_c6_grant",  bus.grant, 4'b1000);
        check("t2_c6_data",   bus.data_in, 8'hC0);
        tick(5); #1;
        check("t2_c11_grant", bus.grant, 4'b0010);
        check("t2_c11_data",  bus.data_in, 8'h44);
        tick(5); #1;
        check("t2_c16_grant", bus.grant, 4'b1000);
        check("t2_no_0_or_2", grant_02_seen - g0, 0);

        // Backpressure after two beats.
        do_reset();
        req_drv = 4'b0001;
        #1;
        e0 = enq_seen;
        tick(3);
        full_drv = 1'b1;
        #1;
        check("t3_stall_enq",   bus.enqueue, 1'b0);
        check("t3_stall_grant", bus.grant, 4'b0001);
        tick(1); #1;
        check("t3_stall_busy",  bus.busy, 1'b1);
        tick(2);
        full_drv = 1'b0;
        #1;
        check("t3_resume_enq",  bus.enqueue, 1'b1);
        check("t3_resume_data", bus.data_in, 8'h02);
        tick(1); #1;
        check("t3_c7_data",     bus.data_in, 8'h03);
        tick(1); #1;
        check("t3_c8_grant",    bus.grant, 4'b0000);
        check("t3_beats",       enq_seen - e0, 4);

        // Early drop by producer 2; producer 3 is next.
        do_reset();
        req_drv = 4'b1100;
        tick(1); #1;
        check("t4_c1_grant", bus.grant, 4'b0100);
        check("t4_c1_data",  bus.data_in, 8'h80);
        tick(1);
        req_drv = 4'b1000;
        #1;
        check("t4_c2_enq",   bus.enqueue, 1'b0);
        tick(1); #1;
        check("t4_c3_grant", bus.grant, 4'b0000);
        check("t4_c3_busy",  bus.busy, 1'b0);
        tick(1); #1;
        check("t4_c4_grant", bus.grant, 4'b1000);
        check("t4_c4_owner", bus.owner, 2'd3);

        // Reset during beat 2 of producer 1.
        do_reset();
        req_drv = 4'b0010;
        tick(2);
        reset = 1'b1;
        #1;
        check("t5_reset_cycle_enq", bus.enqueue, 1'b1);
        tick(1); #1;
        check("t5_grant_cleared", bus.grant, 4'b0000);
        check("t5_busy_cleared",  bus.busy, 1'b0);
        reset   = 1'b0;
        req_drv = 4'b1111;
        tick(1); #1;
        check("t5_first_after_reset", bus.grant, 4'b0001);

        // End-to-end into a capacity-3 FIFO with an idle reader.
        do_reset();
        fifo_mode = 1'b1;
        req_drv   = 4'b1111;
        #1;
        e0 = enq_seen;
        w0 = enq_while_full;
        tick(20); #1;
        check("t6_fifo_count",     fifo_count, 3);
        check("t6_beats",          enq_seen - e0, 3);
        check("t6_enq_while_full", enq_while_full - w0, 0);
        check("t6_stalled_grant",  bus.grant, 4'b0001);

        req_drv   = '0;
        fifo_mode = 1'b0;
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the write port of a `mixed_clock_fifo` between several producers in the write-clock domain. It grants one requester at a time for a bounded burst and forwards the granted data to the FIFO's `data_in`. It drives `enqueue` only when the FIFO reports not-full, so no beat is ever dropped. The block sits directly in front of the FIFO and owns its `enqueue`/`data_in` inputs.

## Interface
- `requesters`, 4, number of producers (≥2)
- `bit_width`, 8, data width; matches the FIFO's `bit_width`
- `max_burst`, 4, maximum beats per grant (≥1)

- `write_clock` in 1: sole clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `request` in `requesters`: per-producer level request; held while data is valid
- `req_data` in `requesters*bit_width`: producer k's data occupies bits [k*bit_width +: bit_width]
- `full` in 1: FIFO `full` flag
- `grant` out `requesters`: registered, one-hot or zero; identifies the current burst owner
- `enqueue` out 1: to FIFO `enqueue`; combinational
- `data_in` out `bit_width`: to FIFO `data_in`; slice of `req_data` selected by the owner
- `owner` out `$clog2(requesters)`: index of the current owner; 0 when idle
- `busy` out 1: high in BURST

## Operation
- States:
  - IDLE: `grant`=0, `enqueue`=0.
  - BURST: `grant[owner]`=1.
- IDLE→BURST: taken when any `request` bit is high and `full`=0.
  - Winner is the first requesting index scanning from `last+1` upward, wrapping modulo `requesters`.
  - On the transition, `owner`←winner and `beats`←0.
- IDLE with `full`=1: stays IDLE regardless of requests.
- In BURST, `enqueue` = `request[owner]` & !`full`. `data_in` = `req_data` slice of `owner`, driven in every state, including IDLE.
- Beat: a cycle with `enqueue`=1. The producer must treat `grant[k]` & `request[k]` & !`full` at the edge as accepted and present the next word the following cycle.
- `beats` increments on each beat. Width is `$clog2(max_burst+1)`.
- BURST→IDLE, with `last`←`owner`, occurs on the edge when either:
  - a beat occurs and `beats`+1 == `max_burst`, or
  - `request[owner]`=0.
- `full`=1 in BURST: the burst stalls. Grant is held, no beat occurs, `beats` is unchanged, and there is no timeout.
- Non-owner requests are ignored during BURST. Requests may change at any time and only take effect at arbitration in IDLE.
- Reset values:
  - State IDLE.
  - `grant`=0, `owner`=0, `busy`=0, `enqueue`=0.
  - `beats`=0.
  - `last`=`requesters`-1, so index 0 has first priority.

## Timing
- Latency from a request seen in IDLE to the grant: 1 cycle. The grant and the first possible `enqueue` both appear in the cycle after the request is sampled.
- Each burst is followed by exactly 1 IDLE cycle, so peak throughput is `max_burst`/(`max_burst`+1).
- Reset wins over all other conditions. Reset asserted mid-burst clears `grant` and `enqueue` in the next cycle. A beat in the reset cycle itself is combinationally visible, so the producer must also gate on reset.
- Wrap-around: when `last`=`requesters`-1, the scan starts at 0.
- Fairness: each continuously requesting producer receives a grant within `requesters`-1 bursts.

## Test plan
- Single burst:
  - Stimulus: reset; `request`=4'b0001 held; `full`=0.
  - Required: `grant`=0001 from cycle 1; 4 beats on cycles 1–4 with `data_in` = producer 0's words; `grant`=0 on cycle 5; new grant on cycle 6.
- Round-robin:
  - Stimulus: `request`=4'b1010 held.
  - Required: grants alternate 0010, 1000, 0010, …, each for 4 beats; never producer 0 or 2.
- Backpressure:
  - Stimulus: mid-burst after 2 beats, `full`=1 for 3 cycles, then 0.
  - Required: `enqueue`=0 and `grant` held during the stall; 2 further beats after release; total 4.
- Early drop:
  - Stimulus: producer 2 granted; `request[2]` falls after 1 beat.
  - Required: IDLE next cycle; `last`=2, so a waiting producer 3 is granted next.
- Reset mid-burst:
  - Stimulus: assert `reset` during beat 2 of producer 1.
  - Required: next cycle `grant`=0, `busy`=0; after release with all requesting, producer 0 is granted first.
- End-to-end with FIFO:
  - Stimulus: arbiter feeding a capacity-3 FIFO; all four producers requesting; reader idle.
  - Required: exactly 3 beats accepted; `enqueue` is never high while `full`=1.
